program_counter_unit: RTL and testbench
=======================================

PROGRAM_COUNTER_UNIT -- requirements
Module: program_counter_unit

Interface
REQ-001 SHALL have parameter RESET_VECTOR, default 32'h0000_0000: PC value loaded on reset.
REQ-002 SHALL have parameter EXC_VECTOR, default 32'h0000_0080: PC value loaded on exception.
REQ-003 SHALL have parameter FLUSH_CYCLES, default 2, legal 1..7: bubble cycles after a redirect.
REQ-004 SHALL have port Clk  input  1  single system clock; all state updates on its rising edge.
REQ-005 SHALL have port Reset  input  1  synchronous, active-low reset.
REQ-006 SHALL have port PCAddResult  input  32  sequential next PC (PC+4) from the downstream PC adder.
REQ-007 SHALL have port BranchTaken  input  1  redirect request this cycle.
REQ-008 SHALL have port BranchTarget  input  32  redirect target address.
REQ-009 SHALL have port Exception  input  1  exception request this cycle.
REQ-010 SHALL have port Halt  input  1  request to freeze fetch.
REQ-011 SHALL have port Resume  input  1  request to leave HALT.
REQ-012 SHALL have port IMemReady  input  1  instruction memory accepts the current fetch.
REQ-013 SHALL have port PCResult  output  32  registered current PC; feeds the PC adder and instruction memory.
REQ-014 SHALL have port FetchValid  output  1  PCResult is a valid fetch request this cycle.
REQ-015 SHALL have port Flush  output  1  downstream fetch/decode stages discard contents.
REQ-016 SHALL have port EPC  output  32  registered PC of the instruction that was current when the exception was taken.

Function
REQ-017 SHALL implement states RUN, FLUSH, HALT; FetchValid=1 only in RUN; Flush=1 only in FLUSH.
REQ-018 In RUN, priority SHALL be Exception > BranchTaken > Halt > IMemReady advance > hold.
REQ-019 RUN+Exception: PCResult<=EXC_VECTOR, EPC<=PCResult, counter<=FLUSH_CYCLES, next FLUSH.
REQ-020 RUN+BranchTaken: PCResult<={BranchTarget[31:2],2'b00}, counter<=FLUSH_CYCLES, next FLUSH.
REQ-021 RUN+Halt: PCResult holds, next HALT.
REQ-022 RUN+IMemReady (no higher request): PCResult<=PCAddResult, one-cycle latency.
REQ-023 RUN with IMemReady=0 and no request: PCResult holds, FetchValid stays 1.
REQ-024 FLUSH: PCResult holds, counter decrements each cycle; at counter==1, next RUN.
REQ-025 FLUSH+Exception: vector, EPC capture, counter reload; EPC captures PCResult (the redirect target).
REQ-026 FLUSH: BranchTaken, Halt and IMemReady ignored.
REQ-027 HALT: PCResult holds; Exception handled as REQ-019; else Resume -> RUN next cycle.
REQ-028 Simultaneous Halt and Resume in HALT: Resume wins.
REQ-029 PCResult arithmetic SHALL wrap: PCAddResult of 32'h0000_0000 after 32'hFFFF_FFFC is accepted unchanged.

Reset
REQ-030 Reset low at a rising edge: PCResult=RESET_VECTOR, EPC=0, counter=0, state RUN, regardless of state or inputs.
REQ-031 While Reset is low, FetchValid=0 and Flush=0.
REQ-032 First edge with Reset high: normal RUN behaviour; reset mid-FLUSH abandons the flush.

Structure
REQ-033 Package pc_unit_pkg SHALL hold the state enum and default vector constants.
REQ-034 The flush down-counter SHALL be sub-module flush_timer (load, decrement, last-cycle flag).
REQ-035 The PC adder SHALL stay external; this block SHALL contain no adder on the PC path.

Verification
REQ-036 Reset low 2 cycles, then IMemReady=1 with PCAddResult=PCResult+4 for 3 cycles: PCResult 0 -> 4 -> 8 -> 12; FetchValid=1.
REQ-037 At PC=8, BranchTaken=1 with BranchTarget=32'h0000_0043: next PCResult=32'h40; Flush=1 and FetchValid=0 for 2 cycles; then RUN.
REQ-038 At PC=12, Exception and BranchTaken together: PCResult=32'h80, EPC=12, Flush=1 for 2 cycles.
REQ-039 At PC=16, Halt=1 for 3 cycles then Resume=1: PCResult stays 16 and FetchValid=0 for 3 cycles; advances to 20 one cycle after RUN resumes.
REQ-040 IMemReady=0 for 4 cycles in RUN: PCResult holds and FetchValid=1 throughout.
REQ-041 Reset low during the 2nd FLUSH cycle: PCResult=0, Flush=0, state RUN after release.

Source files
------------

// File: rtl/pc_unit_pkg.sv
// ============================================================================
// Module  : pc_unit_pkg
// Purpose : Shared state encoding, default vectors and helpers for the PC unit.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

package pc_unit_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_HALT  = 2'd2
    } pc_state_e;

    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_EXC_VECTOR   = 32'h0000_0080;
    localparam int          DEFAULT_FLUSH_CYCLES = 2;
    localparam int          CNT_W                = 3;

    // Masking keeps every target bit referenced while forcing word alignment.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

`default_nettype wire

// File: rtl/flush_timer.sv
// ============================================================================
// Module  : flush_timer
// Purpose : Loadable down-counter that times the post-redirect bubble.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module flush_timer
    import pc_unit_pkg::*;
#(
    parameter int WIDTH = CNT_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             decrement,
    output logic             last
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (decrement && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    assign last = (count == WIDTH'(1));

endmodule

`default_nettype wire

// File: rtl/program_counter_unit.sv
// ============================================================================
// Module  : program_counter_unit
// Purpose : Fetch PC register with redirect, exception, flush and halt control.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module program_counter_unit
    import pc_unit_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
    parameter logic [31:0] EXC_VECTOR   = DEFAULT_EXC_VECTOR,
    parameter int          FLUSH_CYCLES = DEFAULT_FLUSH_CYCLES
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] PCAddResult,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    input  logic        Exception,
    input  logic        Halt,
    input  logic        Resume,
    input  logic        IMemReady,
    output logic [31:0] PCResult,
    output logic        FetchValid,
    output logic        Flush,
    output logic [31:0] EPC
);

    pc_state_e   state;
    logic [31:0] pc_q;
    logic [31:0] epc_q;
    logic        fetch_valid_q;
    logic        flush_q;

    logic        timer_load;
    logic        timer_dec;
    logic        timer_last;

    // An exception reloads the bubble from any state; a branch only from RUN.
    assign timer_load = Exception || ((state == ST_RUN) && BranchTaken);
    assign timer_dec  = (state == ST_FLUSH);

    flush_timer #(
        .WIDTH (CNT_W)
    ) u_flush_timer (
        .clk        (Clk),
        .reset_n    (Reset),
        .load       (timer_load),
        .load_value (CNT_W'(FLUSH_CYCLES)),
        .decrement  (timer_dec),
        .last       (timer_last)
    );

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state         <= ST_RUN;
            pc_q          <= RESET_VECTOR;
            epc_q         <= 32'h0000_0000;
            fetch_valid_q <= 1'b1;
            flush_q       <= 1'b0;
        end else if (Exception) begin
            state         <= ST_FLUSH;
            pc_q          <= EXC_VECTOR;
            epc_q         <= pc_q;
            fetch_valid_q <= 1'b0;
            flush_q       <= 1'b1;
        end else begin
            case (state)
                ST_RUN: begin
                    if (BranchTaken) begin
                        state         <= ST_FLUSH;
                        pc_q          <= word_align(BranchTarget);
                        fetch_valid_q <= 1'b0;
                        flush_q       <= 1'b1;
                    end else if (Halt) begin
                        state         <= ST_HALT;
                        fetch_valid_q <= 1'b0;
                        flush_q       <= 1'b0;
                    end else if (IMemReady) begin
                        // The PC adder is external; its result is taken as-is, so wrap is free.
                        pc_q <= PCAddResult;
                    end
                end
                ST_FLUSH: begin
                    if (timer_last) begin
                        state         <= ST_RUN;
                        fetch_valid_q <= 1'b1;
                        flush_q       <= 1'b0;
                    end
                end
                ST_HALT: begin
                    if (Resume) begin
                        state         <= ST_RUN;
                        fetch_valid_q <= 1'b1;
                        flush_q       <= 1'b0;
                    end
                end
                default: begin
                    state         <= ST_RUN;
                    fetch_valid_q <= 1'b1;
                    flush_q       <= 1'b0;
                end
            endcase
        end
    end

    // Reset must silence the handshake outputs immediately, not one edge later.
    assign PCResult   = pc_q;
    assign EPC        = epc_q;
    assign FetchValid = fetch_valid_q & Reset;
    assign Flush      = flush_q & Reset;

endmodule

`default_nettype wire

// File: tb/tb_program_counter_unit.sv
// Directed-vector bench for program_counter_unit; expectations queued, checked by a monitor.
`default_nettype none

module tb_program_counter_unit;

    logic        Clk;
    logic        Reset;
    logic [31:0] PCAddResult;
    logic        BranchTaken;
    logic [31:0] BranchTarget;
    logic        Exception;
    logic        Halt;
    logic        Resume;
    logic        IMemReady;
    logic [31:0] PCResult;
    logic        FetchValid;
    logic        Flush;
    logic [31:0] EPC;

    program_counter_unit dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .PCAddResult  (PCAddResult),
        .BranchTaken  (BranchTaken),
        .BranchTarget (BranchTarget),
        .Exception    (Exception),
        .Halt         (Halt),
        .Resume       (Resume),
        .IMemReady    (IMemReady),
        .PCResult     (PCResult),
        .FetchValid   (FetchValid),
        .Flush        (Flush),
        .EPC          (EPC)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        int          id;
        logic [31:0] pc;
        logic        fv;
        logic        fl;
        logic [31:0] epc;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_err  = 0;
    int   vec_id = 0;

    always @(negedge Clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            logic bad;
            e   = exp_q.pop_front();
            bad = 1'b0;
            n_vec++;
            if (PCResult !== e.pc) begin
                $display("FAIL vec%0d PCResult: got %h want %h", e.id, PCResult, e.pc);
                bad = 1'b1;
            end
            if (FetchValid !== e.fv) begin
                $display("FAIL vec%0d FetchValid: got %b want %b", e.id, FetchValid, e.fv);
                bad = 1'b1;
            end
            if (Flush !== e.fl) begin
                $display("FAIL vec%0d Flush: got %b want %b", e.id, Flush, e.fl);
                bad = 1'b1;
            end
            if (EPC !== e.epc) begin
                $display("FAIL vec%0d EPC: got %h want %h", e.id, EPC, e.epc);
                bad = 1'b1;
            end
            if (bad) n_err++;
        end
    end

    // Drive one cycle of inputs and queue the state expected after the next rising edge.
    task automatic step(input logic rst_n, input logic ima, input logic [31:0] pcadd,
                        input logic br, input logic [31:0] tgt, input logic exc,
                        input logic hlt, input logic res,
                        input logic [31:0] e_pc, input logic e_fv, input logic e_fl,
                        input logic [31:0] e_epc);
        exp_t e;
        @(negedge Clk);
        #1;
        Reset        = rst_n;
        IMemReady    = ima;
        PCAddResult  = pcadd;
        BranchTaken  = br;
        BranchTarget = tgt;
        Exception    = exc;
        Halt         = hlt;
        Resume       = res;
        vec_id++;
        e.id  = vec_id;
        e.pc  = e_pc;
        e.fv  = e_fv;
        e.fl  = e_fl;
        e.epc = e_epc;
        exp_q.push_back(e);
    endtask

    initial begin
        Reset = 1'b0; IMemReady = 1'b0; PCAddResult = '0; BranchTaken = 1'b0;
        BranchTarget = '0; Exception = 1'b0; Halt = 1'b0; Resume = 1'b0;

        //   rst ima pcadd         br tgt           exc hlt res  pc            fv fl epc
        step(0, 0, 32'h0,          0, 32'h0,        0, 0, 0,   32'h0,        0, 0, 32'h0);
        step(0, 1, 32'h1234,       1, 32'h99,       1, 1, 0,   32'h0,        0, 0, 32'h0);
        step(1, 1, 32'h4,          0, 32'h0,        0, 0, 0,   32'h4,        1, 0, 32'h0);
        step(1, 1, 32'h8,          0, 32'h0,        0, 0, 0,   32'h8,        1, 0, 32'h0);
        // branch at PC=8 to unaligned 0x43
        step(1, 1, 32'hC,          1, 32'h43,       0, 0, 0,   32'h40,       0, 1, 32'h0);
        step(1, 1, 32'h44,         1, 32'h100,      0, 1, 0,   32'h40,       0, 1, 32'h0);
        step(1, 1, 32'h44,         0, 32'h0,        0, 0, 0,   32'h40,       1, 0, 32'h0);
        step(1, 1, 32'h44,         0, 32'h0,        0, 0, 0,   32'h44,       1, 0, 32'h0);
        // memory stall for 4 cycles
        for (int i = 0; i < 4; i++)
            step(1, 0, 32'h48,     0, 32'h0,        0, 0, 0,   32'h44,       1, 0, 32'h0);
        // exception beats a simultaneous branch
        step(1, 1, 32'h48,         1, 32'h200,      1, 0, 0,   32'h80,       0, 1, 32'h44);
        // exception during flush reloads the bubble and captures the vector
        step(1, 0, 32'h0,          0, 32'h0,        1, 0, 0,   32'h80,       0, 1, 32'h80);
        step(1, 0, 32'h0,          0, 32'h0,        0, 0, 0,   32'h80,       0, 1, 32'h80);
        step(1, 0, 32'h0,          0, 32'h0,        0, 0, 0,   32'h80,       1, 0, 32'h80);
        // halt for 3 cycles, then halt+resume together
        step(1, 1, 32'h84,         0, 32'h0,        0, 1, 0,   32'h80,       0, 0, 32'h80);
        step(1, 1, 32'h84,         0, 32'h0,        0, 1, 0,   32'h80,       0, 0, 32'h80);
        step(1, 1, 32'h84,         0, 32'h0,        0, 1, 0,   32'h80,       0, 0, 32'h80);
        step(1, 0, 32'h84,         0, 32'h0,        0, 1, 1,   32'h80,       1, 0, 32'h80);
        step(1, 1, 32'h84,         0, 32'h0,        0, 0, 0,   32'h84,       1, 0, 32'h80);
        // top-of-memory branch then wrap via the external adder
        step(1, 1, 32'h88,         1, 32'hFFFF_FFFF,0, 0, 0,   32'hFFFF_FFFC,0, 1, 32'h80);
        step(1, 1, 32'h88,         0, 32'h0,        0, 0, 0,   32'hFFFF_FFFC,0, 1, 32'h80);
        step(1, 1, 32'h88,         0, 32'h0,        0, 0, 0,   32'hFFFF_FFFC,1, 0, 32'h80);
        step(1, 1, 32'h0,          0, 32'h0,        0, 0, 0,   32'h0,        1, 0, 32'h80);
        step(1, 1, 32'h10,         0, 32'h0,        0, 0, 0,   32'h10,       1, 0, 32'h80);
        // exception taken from HALT
        step(1, 1, 32'h14,         0, 32'h0,        0, 1, 0,   32'h10,       0, 0, 32'h80);
        step(1, 1, 32'h14,         0, 32'h0,        1, 0, 0,   32'h80,       0, 1, 32'h10);
        step(1, 1, 32'h14,         0, 32'h0,        0, 0, 0,   32'h80,       0, 1, 32'h10);
        // reset during the 2nd flush cycle abandons the flush
        step(0, 1, 32'h14,         0, 32'h0,        0, 0, 0,   32'h0,        0, 0, 32'h0);
        step(1, 0, 32'h0,          0, 32'h0,        0, 0, 0,   32'h0,        1, 0, 32'h0);
        step(1, 1, 32'h4,          0, 32'h0,        0, 0, 0,   32'h4,        1, 0, 32'h0);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge Clk);
        @(posedge Clk);
        if (exp_q.size() > 0) begin
            $display("FAIL drain: %0d expected vectors never checked, want 0", exp_q.size());
            n_err++;
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
